ahb_slave_mem: RTL and testbench

// - AHB-Lite slave: word-organised RAM that answers one slave slot of the decoder/read-data mux.
// - Drives hrdata/hreadyout/hresp, which feed the hrdata_N/hready_N/hresp_N mux inputs.
// - Supports programmable wait states, byte/halfword/word writes and a two-cycle ERROR response.

---
 rtl/ahb_slave_mem_if.sv | 24 ++
 rtl/ahb_slave_mem.sv | 116 +++++++++++
 tb/tb_ahb_slave_mem.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite slave-slot signal bundle: address/data-phase inputs from the bus and
// the slot's response outputs toward the read-data/ready mux.
interface ahb_slave_mem_if;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic        hresp;

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        output hrdata, hreadyout, hresp
    );

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        input  hrdata, hreadyout, hresp
    );
endinterface

// File: rtl/ahb_slave_mem.sv
// AHB-Lite word RAM slave with programmable wait states and two-cycle ERROR.
// Define AHB_SLV_ERR_EN to make out-of-range offsets raise ERROR instead of wrapping.
module ahb_slave_mem #(
    parameter int          MEM_WORDS   = 256,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic              hclk,
    input  logic              hreset,
    ahb_slave_mem_if.slave    bus
);
    localparam int         AW      = $clog2(MEM_WORDS);
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [3:0]    be_q, be_d;
    logic          wr_q, wr_d;

    logic [31:0]   mem [MEM_WORDS];

    logic [31:0]   offset;
    logic          accept;
    logic          illegal;
    logic [3:0]    be;
    logic          unused;

    assign offset = bus.haddr - BASE_ADDR;
    assign accept = bus.hsel & bus.hready & bus.htrans[1];
    assign unused = ^{offset[31:AW+2], offset[1:0], bus.htrans[0]};

    // Lane enables and legality of the transfer being offered in the address phase
    always_comb begin
        be      = 4'b0000;
        illegal = 1'b0;
        case (bus.hsize)
            3'b000:  be = 4'b0001 << bus.haddr[1:0];
            3'b001: begin
                be      = bus.haddr[1] ? 4'b1100 : 4'b0011;
                illegal = bus.haddr[0];
            end
            3'b010: begin
                be      = 4'b1111;
                illegal = |bus.haddr[1:0];
            end
            default: illegal = 1'b1;
        endcase
`ifdef AHB_SLV_ERR_EN
        if (|offset[31:AW+2]) illegal = 1'b1;
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        be_d    = be_q;
        wr_d    = wr_q;
        case (state_q)
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_DATA;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                // IDLE, DATA and ERR2 all drive hreadyout=1, so a new address phase may land here
                state_d = S_IDLE;
                if (accept) begin
                    idx_d = offset[AW+1:2];
                    be_d  = be;
                    wr_d  = bus.hwrite;
                    if (illegal) begin
                        state_d = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WS_LOAD;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            be_q    <= 4'b0000;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            be_q    <= be_d;
            wr_q    <= wr_d;
        end
    end

    // RAM is not reset; a reset edge during the write's DATA cycle drops the write
    always_ff @(posedge hclk) begin
        if (!hreset && state_q == S_DATA && wr_q) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) mem[idx_q][8*b +: 8] <= bus.hwdata[8*b +: 8];
            end
        end
    end

    assign bus.hreadyout = !(state_q == S_WAIT || state_q == S_ERR1);
    assign bus.hresp     = (state_q == S_ERR1 || state_q == S_ERR2);
    assign bus.hrdata    = (state_q == S_DATA && !wr_q) ? mem[idx_q] : 32'h0;
endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: two slots (0 and 3 wait states) driven by directed
// transfers; a transfer-level model predicts every response cycle.
module tb_ahb_slave_mem;
    logic hclk = 1'b0;
    logic hreset = 1'b1;
    always #5 hclk = ~hclk;

    ahb_slave_mem_if bus0();
    ahb_slave_mem_if bus1();

    logic        sel;
    logic        hsel_v, hwrite_v;
    logic [1:0]  htrans_v;
    logic [2:0]  hsize_v;
    logic [31:0] haddr_v, hwdata_v;

    assign bus0.hsel   = hsel_v & ~sel;
    assign bus1.hsel   = hsel_v & sel;
    assign bus0.haddr  = haddr_v;   assign bus1.haddr  = haddr_v;
    assign bus0.htrans = htrans_v;  assign bus1.htrans = htrans_v;
    assign bus0.hwrite = hwrite_v;  assign bus1.hwrite = hwrite_v;
    assign bus0.hsize  = hsize_v;   assign bus1.hsize  = hsize_v;
    assign bus0.hwdata = hwdata_v;  assign bus1.hwdata = hwdata_v;
    assign bus0.hready = bus0.hreadyout;
    assign bus1.hready = bus1.hreadyout;

    ahb_slave_mem #(.MEM_WORDS(256), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut0 (
        .hclk(hclk), .hreset(hreset), .bus(bus0));
    ahb_slave_mem #(.MEM_WORDS(256), .WAIT_STATES(3), .BASE_ADDR(32'h0)) dut1 (
        .hclk(hclk), .hreset(hreset), .bus(bus1));

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } tx_t;

    typedef struct {
        logic        rdy;
        logic        resp;
        logic [31:0] data;
        logic        isrd;
    } exp_t;

    int          total = 0;
    int          bad = 0;
    exp_t        eq0[$];
    exp_t        eq1[$];
    tx_t         txq[$];
    logic [31:0] mm [2][256];
    logic [31:0] last_rd [2];
    int          nzero [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic qpush(input int d, input exp_t e);
        if (d == 0) eq0.push_back(e);
        else        eq1.push_back(e);
    endtask

    // Transfer-level model: legality, lane merge and response sequence per accept
    task automatic model_accept(input int d, input tx_t t);
        bit   ill;
        int   idx;
        int   ws;
        logic [31:0] w;
        ws  = (d == 0) ? 0 : 3;
        ill = (t.size > 3'd2) || (t.size == 3'd1 && t.addr[0]) ||
              (t.size == 3'd2 && t.addr[1:0] != 2'b00);
`ifdef AHB_SLV_ERR_EN
        ill = ill || (t.addr >= 32'h400);
`endif
        idx = int'((t.addr >> 2) & 32'hFF);
        if (ill) begin
            qpush(d, '{1'b0, 1'b1, 32'h0, 1'b0});
            qpush(d, '{1'b1, 1'b1, 32'h0, 1'b0});
        end else begin
            repeat (ws) qpush(d, '{1'b0, 1'b0, 32'h0, 1'b0});
            if (t.wr) begin
                w = mm[d][idx];
                for (int b = 0; b < 4; b++) begin
                    if ((t.size == 3'd2) ||
                        (t.size == 3'd1 && b / 2 == int'(t.addr[1])) ||
                        (t.size == 3'd0 && b == int'(t.addr[1:0])))
                        w[8*b +: 8] = t.wdata[8*b +: 8];
                end
                mm[d][idx] = w;
                qpush(d, '{1'b1, 1'b0, 32'h0, 1'b0});
            end else begin
                qpush(d, '{1'b1, 1'b0, mm[d][idx], 1'b1});
            end
        end
    endtask

    task automatic chk_bus(input int d, input logic rdy, input logic resp, input logic [31:0] dat);
        exp_t e;
        e = '{1'b1, 1'b0, 32'h0, 1'b0};
        if (d == 0) begin
            if (eq0.size() > 0) e = eq0.pop_front();
        end else begin
            if (eq1.size() > 0) e = eq1.pop_front();
        end
        chk($sformatf("d%0d hreadyout", d), {31'h0, rdy}, {31'h0, e.rdy});
        chk($sformatf("d%0d hresp", d), {31'h0, resp}, {31'h0, e.resp});
        chk($sformatf("d%0d hrdata", d), dat, e.data);
        if (!rdy) nzero[d]++;
        if (e.isrd) last_rd[d] = dat;
    endtask

    always @(negedge hclk) begin
        if (!hreset) begin
            chk_bus(0, bus0.hreadyout, bus0.hresp, bus0.hrdata);
            chk_bus(1, bus1.hreadyout, bus1.hresp, bus1.hrdata);
        end
    end

    function automatic tx_t mk(input logic [31:0] a, input logic w, input logic [2:0] s,
                               input logic [31:0] wd);
        tx_t t;
        t.addr = a; t.wr = w; t.size = s; t.wdata = wd;
        return t;
    endfunction

    // Issues txq back-to-back on slot d, then waits for its responses to drain
    task automatic run(input int d);
        tx_t t;
        bool_loop: begin end
        @(posedge hclk); #1;
        sel = (d == 1);
        while (txq.size() > 0) begin
            bit ok;
            t = txq.pop_front();
            hsel_v = 1'b1; htrans_v = 2'b10; haddr_v = t.addr;
            hwrite_v = t.wr; hsize_v = t.size;
            ok = 1'b0;
            for (int n = 0; n < 40 && !ok; n++) begin
                @(negedge hclk);
                ok = (d == 0) ? bus0.hreadyout : bus1.hreadyout;
            end
            if (!ok) chk("accept_timeout", 32'h0, 32'h1);
            @(posedge hclk);
            model_accept(d, t);
            #1;
            if (t.wr) hwdata_v = t.wdata;
        end
        hsel_v = 1'b0; htrans_v = 2'b00;
        for (int n = 0; n < 40 && (eq0.size() + eq1.size()) > 0; n++) @(negedge hclk);
        if ((eq0.size() + eq1.size()) > 0) chk("drain_timeout", 32'h0, 32'h1);
    endtask

    initial begin
        int nz;
        sel = 1'b0; hsel_v = 1'b0; hwrite_v = 1'b0; htrans_v = 2'b00;
        hsize_v = 3'd2; haddr_v = 32'h0; hwdata_v = 32'h0;
        nzero[0] = 0; nzero[1] = 0;
        last_rd[0] = 32'h0; last_rd[1] = 32'h0;

        hreset = 1'b1;
        repeat (2) @(posedge hclk);
        #1 hreset = 1'b0;
        @(negedge hclk);
        chk("rst d0 hreadyout", {31'h0, bus0.hreadyout}, 32'h1);
        chk("rst d0 hresp",     {31'h0, bus0.hresp},     32'h0);
        chk("rst d0 hrdata",    bus0.hrdata,             32'h0);
        chk("rst d1 hreadyout", {31'h0, bus1.hreadyout}, 32'h1);

        // zero-wait write then read back-to-back
        txq.push_back(mk(32'h10, 1'b1, 3'd2, 32'hDEAD_BEEF));
        txq.push_back(mk(32'h10, 1'b0, 3'd2, 32'h0));
        run(0);
        chk("rd_deadbeef", last_rd[0], 32'hDEAD_BEEF);

        // byte and halfword lane merges
        txq.push_back(mk(32'h10, 1'b1, 3'd2, 32'h1122_3344));
        txq.push_back(mk(32'h13, 1'b1, 3'd0, 32'hA5A5_A5A5));
        txq.push_back(mk(32'h10, 1'b0, 3'd2, 32'h0));
        run(0);
        chk("rd_byte_merge", last_rd[0], 32'hA522_3344);
        txq.push_back(mk(32'h12, 1'b1, 3'd1, 32'hCAFE_0000));
        txq.push_back(mk(32'h11, 1'b1, 3'd0, 32'h0000_7700));
        txq.push_back(mk(32'h10, 1'b0, 3'd0, 32'h0));
        run(0);
        chk("rd_half_merge", last_rd[0], 32'hCAFE_7744);

        // misaligned / illegal-size errors leave RAM intact
        txq.push_back(mk(32'h0, 1'b1, 3'd2, 32'h0123_4567));
        txq.push_back(mk(32'h2, 1'b1, 3'd2, 32'hFFFF_FFFF));
        txq.push_back(mk(32'h1, 1'b1, 3'd1, 32'hFFFF_FFFF));
        txq.push_back(mk(32'h0, 1'b1, 3'd3, 32'hFFFF_FFFF));
        txq.push_back(mk(32'h0, 1'b0, 3'd2, 32'h0));
        run(0);
        chk("rd_after_err", last_rd[0], 32'h0123_4567);

        // out-of-range: wraps to word 0 or errors depending on build
        txq.push_back(mk(32'h400, 1'b0, 3'd2, 32'h0));
        run(0);
`ifndef AHB_SLV_ERR_EN
        chk("rd_wrap_0x400", last_rd[0], 32'h0123_4567);
`endif

        // BUSY with hsel=1 is a zero-wait OKAY and must not write
        @(posedge hclk); #1;
        sel = 1'b0; hsel_v = 1'b1; htrans_v = 2'b01; hwrite_v = 1'b1;
        haddr_v = 32'h0; hsize_v = 3'd2; hwdata_v = 32'hFFFF_FFFF;
        repeat (2) @(posedge hclk);
        #1 hsel_v = 1'b0; htrans_v = 2'b00;
        txq.push_back(mk(32'h0, 1'b0, 3'd2, 32'h0));
        run(0);
        chk("rd_after_busy", last_rd[0], 32'h0123_4567);

        // three wait states
        txq.push_back(mk(32'h4, 1'b1, 3'd2, 32'h55AA_55AA));
        run(1);
        nz = nzero[1];
        txq.push_back(mk(32'h4, 1'b0, 3'd2, 32'h0));
        run(1);
        chk("ws3_wait_cycles", 32'(nzero[1] - nz), 32'd3);
        chk("ws3_rd", last_rd[1], 32'h55AA_55AA);
        txq.push_back(mk(32'h8, 1'b1, 3'd2, 32'h0BAD_F00D));
        txq.push_back(mk(32'h8, 1'b0, 3'd2, 32'h0));
        txq.push_back(mk(32'h6, 1'b0, 3'd2, 32'h0));
        run(1);
        chk("ws3_raw", last_rd[1], 32'h0BAD_F00D);

        // reset during the wait of a write discards it
        txq.push_back(mk(32'h20, 1'b1, 3'd2, 32'h1111_1111));
        run(1);
        @(posedge hclk); #1;
        sel = 1'b1; hsel_v = 1'b1; htrans_v = 2'b10; hwrite_v = 1'b1;
        hsize_v = 3'd2; haddr_v = 32'h20;
        @(posedge hclk); #1;
        hsel_v = 1'b0; htrans_v = 2'b00; hwdata_v = 32'h9999_9999; hreset = 1'b1;
        @(posedge hclk); #1;
        hreset = 1'b0;
        @(negedge hclk);
        chk("rst_mid d1 hreadyout", {31'h0, bus1.hreadyout}, 32'h1);
        repeat (5) @(posedge hclk);
        txq.push_back(mk(32'h20, 1'b0, 3'd2, 32'h0));
        run(1);
        chk("rd_after_mid_rst", last_rd[1], 32'h1111_1111);

        repeat (2) @(posedge hclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
